cska_seq_adder: RTL and testbench
=================================

# cska_seq_adder

Sequenced wide adder: computes DATA_W-bit sums by iterating a single SLICE_W-bit carry-lookahead slice over DATA_W/SLICE_W cycles, with the inter-slice carry held in a register. Carry-skip propagate information is accumulated across slices and reported alongside the result. It sits between an operand producer and a result consumer, with valid/ready handshakes on both sides, and replaces a full-width adder where area matters more than latency.

## Interface
- DATA_W, 32, operand/result width; must be a multiple of SLICE_W.
- SLICE_W, 4, bits processed per cycle; must be >= 2.
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand set valid.
- in_ready  out  1  block can accept operands; high only in IDLE.
- a, b  in  DATA_W  operands; sampled on acceptance.
- cin  in  1  carry-in; sampled on acceptance.
- op_sub  in  1  subtract select; present only with CSKA_SUB_EN.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- sum  out  DATA_W  result.
- cout  out  1  carry-out of the MSB slice.
- all_prop  out  1  AND of every slice propagate (a^b all ones).
- busy  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1. If in_valid=1, latch a, b, and the initial carry; set slice index k=0 and prop_acc=1; go to RUN.
- RUN: each cycle, feed slice k of a, b and the carry register to the slice. Write the slice sum into sum[k*SLICE_W +: SLICE_W]. Load the carry register with the slice carry-out. Update prop_acc &= slice propagate. Increment k.
- Skip rule: when the slice propagate is 1, the carry-out equals the carry-in. The carry register is loaded from the skip mux. This is functionally identical to ripple and must be checked by an assertion.
- After slice NSLICE-1 (NSLICE = DATA_W/SLICE_W), go to DONE. Set cout to the final carry and all_prop to prop_acc.
- DONE: out_valid=1. sum, cout and all_prop hold stable until out_ready=1, then go to IDLE.
- in_valid is ignored outside IDLE. Operands must not change the result once accepted.
- Arithmetic is modulo 2^DATA_W. Carry out of the MSB goes only to cout.
- Index counter width is clog2(NSLICE), or 1 bit if NSLICE=1. k never wraps within RUN.
- A parameter violation raises an elaboration-time error.

## Timing
- Reset values: state=IDLE, in_ready=1 (decoded from state), out_valid=0, busy=0, sum=0, cout=0, all_prop=0, carry register=0, k=0.
- Acceptance is the edge where in_valid & in_ready. out_valid rises exactly NSLICE cycles after that edge (8 for the defaults).
- The result handshake completes on the edge where out_valid & out_ready. in_ready rises the following cycle.
- Minimum period between acceptances is NSLICE+2 cycles.
- Outputs are registered. in_ready and busy are decoded from the state register, with no combinational path from inputs.
- Reset asserted in any state immediately returns all outputs to their reset values. The in-flight operation is discarded.

## Configuration
- CSKA_SUB_EN defined:
  - op_sub port exists.
  - On acceptance with op_sub=1, b is stored inverted and the initial carry is 1 (cin is ignored), giving a-b.
  - With op_sub=0, behaviour is a normal add using cin.
- CSKA_SUB_EN undefined: the op_sub port and the inversion logic are absent, and the block only adds.

## Structure
- Package cska_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - a function computing NSLICE and the index width from DATA_W and SLICE_W.
- One sub-module, cska_slice: purely combinational SLICE_W-bit carry-lookahead slice with outputs sum, carry-out and block propagate. Instantiated once.
- The FSM, counter, carry register and result register live in cska_seq_adder.

## Test plan
- a=0x00000001, b=0x00000002, cin=0 -> sum=0x00000003, cout=0, all_prop=0; out_valid exactly 8 cycles after acceptance.
- a=0xFFFF0000, b=0x0000FFFF, cin=1 -> sum=0x00000000, cout=1, all_prop=1 (full skip chain).
- Backpressure: result ready, out_ready held low 5 cycles -> sum/cout stable, in_ready=0, a concurrent in_valid pulse with new operands is ignored. Then out_ready=1 -> in_ready=1 next cycle.
- rst_n pulsed low on the 3rd RUN cycle -> out_valid=0, sum=0, busy=0, in_ready=1 during and after reset. The next operation (7+8) returns sum=15.
- Back-to-back: 0xFFFFFFFF+0x00000001 then 0x12345678+0x11111111 with in_valid held high -> sums 0x00000000 (cout=1) then 0x23456789 (cout=0); second acceptance occurs in the IDLE cycle after the first result handshake.
- CSKA_SUB_EN: a=5, b=7, op_sub=1 -> sum=0xFFFFFFFE, cout=0. a=7, b=5, op_sub=1 -> sum=0x00000002, cout=1.

Source files
------------

// File: rtl/cska_pkg.sv
// Shared types and sizing helpers for the sequenced carry-skip adder.
// The optional subtract path is enabled by defining CSKA_SUB_EN.
package cska_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } cska_state_e;

    function automatic int calc_nslice(input int data_w, input int slice_w);
        return data_w / slice_w;
    endfunction

    // Index width never drops below one bit, so a single-slice build still has a counter.
    function automatic int calc_idx_w(input int data_w, input int slice_w);
        int n;
        n = data_w / slice_w;
        return (n > 32'sd1) ? $clog2(n) : 32'sd1;
    endfunction

endpackage

// File: rtl/cska_seq_adder_if.sv
// Operand/result handshake bundle for cska_seq_adder.
// The op_sub signal exists only when CSKA_SUB_EN is defined.
interface cska_seq_adder_if #(parameter int DATA_W = 32);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic              cin;
`ifdef CSKA_SUB_EN
    logic              op_sub;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] sum;
    logic              cout;
    logic              all_prop;
    logic              busy;

    modport master (
        output in_valid, a, b, cin, out_ready,
`ifdef CSKA_SUB_EN
        output op_sub,
`endif
        input  in_ready, out_valid, sum, cout, all_prop, busy
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
`ifdef CSKA_SUB_EN
        input  op_sub,
`endif
        output in_ready, out_valid, sum, cout, all_prop, busy
    );
endinterface

// File: rtl/cska_seq_adder_chk.sv
// Checks that the skip-muxed carry and the slice sum agree with a plain ripple add.
// Used by cska_seq_adder in both the add-only and CSKA_SUB_EN builds.
module cska_seq_adder_chk #(
    parameter int SLICE_W = 4
) (
    input logic               clk,
    input logic               rst_n,
    input logic               en,
    input logic [SLICE_W-1:0] a,
    input logic [SLICE_W-1:0] b,
    input logic               cin,
    input logic [SLICE_W-1:0] sum,
    input logic               carry
);
    logic [SLICE_W:0] ripple_s;

    assign ripple_s = {1'b0, a} + {1'b0, b} + {{SLICE_W{1'b0}}, cin};

    a_skip_eq_ripple: assert property (@(posedge clk) disable iff (!rst_n)
        en |-> (carry == ripple_s[SLICE_W]));

    a_sum_eq_ripple: assert property (@(posedge clk) disable iff (!rst_n)
        en |-> (sum == ripple_s[SLICE_W-1:0]));
endmodule

// File: rtl/cska_slice.sv
// Combinational SLICE_W-bit carry-lookahead slice with block propagate output.
// Identical in the add-only and CSKA_SUB_EN builds.
module cska_slice #(
    parameter int SLICE_W = 4
) (
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b,
    input  logic               cin,
    output logic [SLICE_W-1:0] sum,
    output logic               cout,
    output logic               prop
);
    logic [SLICE_W-1:0] g_s;
    logic [SLICE_W-1:0] p_s;
    logic [SLICE_W:0]   c_s;
    logic               grp_g_s;
    logic               grp_p_s;

    // Prefix group generate/propagate so every carry is a function of cin, not of the previous carry.
    always_comb begin
        g_s     = a & b;
        p_s     = a ^ b;
        c_s     = '0;
        c_s[0]  = cin;
        grp_g_s = 1'b0;
        grp_p_s = 1'b1;
        for (int i = 0; i < SLICE_W; i++) begin
            grp_g_s    = g_s[i] | (p_s[i] & grp_g_s);
            grp_p_s    = p_s[i] & grp_p_s;
            c_s[i + 1] = grp_g_s | (grp_p_s & cin);
        end
    end

    assign sum  = p_s ^ c_s[SLICE_W-1:0];
    assign cout = c_s[SLICE_W];
    assign prop = &p_s;
endmodule

// File: rtl/cska_seq_adder.sv
// Sequenced wide adder: one carry-lookahead slice iterated over DATA_W/SLICE_W cycles.
// Define CSKA_SUB_EN to add the op_sub port and the a-b path.
module cska_seq_adder
    import cska_pkg::*;
#(
    parameter int DATA_W  = 32,
    parameter int SLICE_W = 4
) (
    input logic              clk,
    input logic              rst_n,
    cska_seq_adder_if.slave  bus
);
    localparam int NSLICE = calc_nslice(DATA_W, SLICE_W);
    localparam int IDX_W  = calc_idx_w(DATA_W, SLICE_W);
    localparam logic [IDX_W-1:0] K_LAST = IDX_W'(NSLICE - 1);

    generate
        if ((SLICE_W < 2) || ((DATA_W % SLICE_W) != 0)) begin : g_bad_param
            $error("cska_seq_adder: DATA_W must be a multiple of SLICE_W and SLICE_W >= 2");
        end
    endgenerate

    cska_state_e       state_q, state_d;
    logic [IDX_W-1:0]  k_q, k_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              carry_q, carry_d;
    logic              prop_acc_q, prop_acc_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              cout_q, cout_d;
    logic              all_prop_q, all_prop_d;

    logic [DATA_W-1:0]  b_in_s;
    logic               cin_in_s;
    logic [31:0]        slice_lo_s;
    logic [SLICE_W-1:0] slice_a_s;
    logic [SLICE_W-1:0] slice_b_s;
    logic [SLICE_W-1:0] slice_sum_s;
    logic               slice_cout_s;
    logic               slice_prop_s;
    logic               skip_carry_s;

`ifdef CSKA_SUB_EN
    // Subtraction stores ~b and forces the initial carry to one; cin is ignored.
    always_comb begin
        if (bus.op_sub) begin
            b_in_s   = ~bus.b;
            cin_in_s = 1'b1;
        end else begin
            b_in_s   = bus.b;
            cin_in_s = bus.cin;
        end
    end
`else
    assign b_in_s   = bus.b;
    assign cin_in_s = bus.cin;
`endif

    assign slice_lo_s = 32'(k_q) * 32'(SLICE_W);
    assign slice_a_s  = a_q[slice_lo_s +: SLICE_W];
    assign slice_b_s  = b_q[slice_lo_s +: SLICE_W];

    cska_slice #(.SLICE_W(SLICE_W)) u_slice (
        .a    (slice_a_s),
        .b    (slice_b_s),
        .cin  (carry_q),
        .sum  (slice_sum_s),
        .cout (slice_cout_s),
        .prop (slice_prop_s)
    );

    // A fully propagating slice passes its carry-in straight through.
    assign skip_carry_s = slice_prop_s ? carry_q : slice_cout_s;

    cska_seq_adder_chk #(.SLICE_W(SLICE_W)) u_chk (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == RUN),
        .a     (slice_a_s),
        .b     (slice_b_s),
        .cin   (carry_q),
        .sum   (slice_sum_s),
        .carry (skip_carry_s)
    );

    // Next-state and datapath updates for the IDLE/RUN/DONE sequence.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        a_d        = a_q;
        b_d        = b_q;
        carry_d    = carry_q;
        prop_acc_d = prop_acc_q;
        sum_d      = sum_q;
        cout_d     = cout_q;
        all_prop_d = all_prop_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d    = RUN;
                    a_d        = bus.a;
                    b_d        = b_in_s;
                    carry_d    = cin_in_s;
                    k_d        = '0;
                    prop_acc_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                sum_d[slice_lo_s +: SLICE_W] = slice_sum_s;
                carry_d    = skip_carry_s;
                prop_acc_d = prop_acc_q & slice_prop_s;
                if (k_q == K_LAST) begin
                    state_d    = DONE;
                    cout_d     = skip_carry_s;
                    all_prop_d = prop_acc_q & slice_prop_s;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any in-flight operation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            k_q        <= '0;
            a_q        <= '0;
            b_q        <= '0;
            carry_q    <= 1'b0;
            prop_acc_q <= 1'b0;
            sum_q      <= '0;
            cout_q     <= 1'b0;
            all_prop_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            a_q        <= a_d;
            b_q        <= b_d;
            carry_q    <= carry_d;
            prop_acc_q <= prop_acc_d;
            sum_q      <= sum_d;
            cout_q     <= cout_d;
            all_prop_q <= all_prop_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.cout      = cout_q;
    assign bus.all_prop  = all_prop_q;
endmodule

// File: tb/tb_cska_seq_adder.sv
// Directed vector bench for cska_seq_adder; subtract vectors are added when CSKA_SUB_EN is defined.
module tb_cska_seq_adder;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic        sub;
        logic [31:0] sum;
        logic        cout;
        logic        allp;
    } vec_t;

    logic clk;
    logic rst_n;
    int   tests;
    int   failed;
    vec_t vecs[$];

    cska_seq_adder_if #(.DATA_W(32)) bus ();

    cska_seq_adder #(.DATA_W(32), .SLICE_W(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic drive_ops(input vec_t v);
        bus.a   = v.a;
        bus.b   = v.b;
        bus.cin = v.cin;
`ifdef CSKA_SUB_EN
        bus.op_sub = v.sub;
`endif
    endtask

    // Called just after a negedge with in_ready high; returns at the negedge where out_valid is seen.
    task automatic start_and_wait(input vec_t v, output int lat);
        drive_ops(v);
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic do_op(input vec_t v, input string tag);
        int lat;
        check({tag, " in_ready_before"}, 64'(bus.in_ready), 64'd1);
        start_and_wait(v, lat);
        check({tag, " latency"}, 64'(lat), 64'd8);
        check({tag, " sum"}, 64'(bus.sum), 64'(v.sum));
        check({tag, " cout"}, 64'(bus.cout), 64'(v.cout));
        check({tag, " all_prop"}, 64'(bus.all_prop), 64'(v.allp));
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, " in_ready_after"}, 64'(bus.in_ready), 64'd1);
    endtask

    initial begin
        vec_t v;
        int   lat;
        tests  = 0;
        failed = 0;

        vecs.push_back('{32'h00000001, 32'h00000002, 1'b0, 1'b0, 32'h00000003, 1'b0, 1'b0});
        vecs.push_back('{32'hFFFF0000, 32'h0000FFFF, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b1});
        vecs.push_back('{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0});
        vecs.push_back('{32'hAAAAAAAA, 32'h55555555, 1'b0, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b1});
        vecs.push_back('{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0});
        vecs.push_back('{32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b1, 1'b0});
        vecs.push_back('{32'h0000000F, 32'h00000001, 1'b0, 1'b0, 32'h00000010, 1'b0, 1'b0});
        vecs.push_back('{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0});
`ifdef CSKA_SUB_EN
        vecs.push_back('{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0});
        vecs.push_back('{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000002, 1'b1, 1'b0});
`endif

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.cin       = 1'b0;
`ifdef CSKA_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        repeat (2) @(negedge clk);
        check("reset out_valid", 64'(bus.out_valid), 64'd0);
        check("reset in_ready", 64'(bus.in_ready), 64'd1);
        check("reset busy", 64'(bus.busy), 64'd0);
        check("reset sum", 64'(bus.sum), 64'd0);
        check("reset cout", 64'(bus.cout), 64'd0);
        check("reset all_prop", 64'(bus.all_prop), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < vecs.size(); i++) begin
            do_op(vecs[i], $sformatf("vec%0d", i));
        end

        // Backpressure: result held for 5 cycles, a stray in_valid pulse must be ignored.
        v = '{32'h11111111, 32'h22222222, 1'b0, 1'b0, 32'h33333333, 1'b0, 1'b0};
        start_and_wait(v, lat);
        check("bp latency", 64'(lat), 64'd8);
        for (int i = 0; i < 5; i++) begin
            check("bp sum", 64'(bus.sum), 64'h33333333);
            check("bp cout", 64'(bus.cout), 64'd0);
            check("bp in_ready", 64'(bus.in_ready), 64'd0);
            check("bp out_valid", 64'(bus.out_valid), 64'd1);
            if (i == 1) begin
                bus.a        = 32'hDEADBEEF;
                bus.b        = 32'h01010101;
                bus.in_valid = 1'b1;
            end else begin
                bus.in_valid = 1'b0;
            end
            @(posedge clk);
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("bp in_ready_after", 64'(bus.in_ready), 64'd1);
        check("bp out_valid_after", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check("bp no_stray_accept", 64'(bus.busy), 64'd0);

        // Reset asserted during the third RUN cycle discards the operation.
        drive_ops('{32'h000000FF, 32'h00000011, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0});
        bus.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        check("rst busy_before", 64'(bus.busy), 64'd1);
        rst_n = 1'b0;
        #1;
        check("rst out_valid", 64'(bus.out_valid), 64'd0);
        check("rst sum", 64'(bus.sum), 64'd0);
        check("rst busy", 64'(bus.busy), 64'd0);
        check("rst in_ready", 64'(bus.in_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst busy_after", 64'(bus.busy), 64'd0);
        check("rst in_ready_after", 64'(bus.in_ready), 64'd1);
        check("rst sum_after", 64'(bus.sum), 64'd0);
        do_op('{32'h00000007, 32'h00000008, 1'b0, 1'b0, 32'h0000000F, 1'b0, 1'b0}, "post_rst");

        // Back-to-back with in_valid and out_ready held high.
        bus.a         = 32'hFFFFFFFF;
        bus.b         = 32'h00000001;
        bus.cin       = 1'b0;
`ifdef CSKA_SUB_EN
        bus.op_sub    = 1'b0;
`endif
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.a = 32'h12345678;
        bus.b = 32'h11111111;
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b first latency", 64'(lat), 64'd8);
        check("b2b first sum", 64'(bus.sum), 64'h00000000);
        check("b2b first cout", 64'(bus.cout), 64'd1);
        @(posedge clk);
        @(negedge clk);
        check("b2b idle in_ready", 64'(bus.in_ready), 64'd1);
        check("b2b idle out_valid", 64'(bus.out_valid), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        check("b2b second accepted", 64'(bus.busy), 64'd1);
        lat = 0;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            @(negedge clk);
            lat++;
        end
        check("b2b second latency", 64'(lat), 64'd8);
        check("b2b second sum", 64'(bus.sum), 64'h23456789);
        check("b2b second cout", 64'(bus.cout), 64'd0);
        @(posedge clk);
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("b2b final in_ready", 64'(bus.in_ready), 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
